alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/flow_pkg.sv | 27 ++
 rtl/alu_writeback_if.sv | 33 +++
 rtl/wb_fifo2.sv | 56 +++++
 rtl/alu_writeback.sv | 79 +++++++
 tb/tb_alu_writeback.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/flow_pkg.sv
// Shared widths, ALU opcode constants and the writeback entry type for the
// ALU result path.
package flow_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned RADDR_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SHL = 4'h5,
        ALU_SHR = 4'h6,
        ALU_MUL = 4'h7,
        ALU_DIV = 4'h8
    } alu_op_e;

    typedef struct packed {
        logic [WORD_W-1:0]  c;
        logic               ofl;
        logic               err;
        logic [RADDR_W-1:0] dst;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// Result handshake, register-file write port and status/trap signals of the
// writeback stage, bundled for connection between producer and writeback.
interface alu_writeback_if;
    import flow_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_c;
    logic               in_ofl;
    logic               in_err;
    logic [RADDR_W-1:0] in_dst;
    logic               rf_stall;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_addr;
    logic [WORD_W-1:0]  rf_wdata;
    logic               status_clr;
    logic               ofl_sticky;
    logic               err_sticky;
    logic               trap;
    logic               trap_ack;
    logic               halted;

    modport master (
        output in_valid, in_c, in_ofl, in_err, in_dst, rf_stall, status_clr, trap_ack,
        input  in_ready, rf_we, rf_addr, rf_wdata, ofl_sticky, err_sticky, trap, halted
    );

    modport slave (
        input  in_valid, in_c, in_ofl, in_err, in_dst, rf_stall, status_clr, trap_ack,
        output in_ready, rf_we, rf_addr, rf_wdata, ofl_sticky, err_sticky, trap, halted
    );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO of writeback entries; entry 0 is always the head.
// flush empties it and takes priority over a same-cycle push.
module wb_fifo2
    import flow_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic [1:0] count
);

    wb_entry_t e0;
    wb_entry_t e1;

    assign dout = e0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        e0    <= din;
                        count <= 2'd1;
                    end else if (count == 2'd1) begin
                        e1    <= din;
                        count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count != 2'd0) begin
                        e0    <= e1;
                        count <= count - 2'd1;
                    end
                end
                2'b11: begin
                    // Pop and push together: the new entry lands behind whatever survives.
                    if (count == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0    <= din;
                        count <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers results in a 2-deep FIFO, retires them into the
// register file, tracks sticky ofl/err flags and halts on trapping results.
module alu_writeback
    import flow_pkg::*;
#(
    parameter bit TRAP_ON_OFL = 1'b0,
    parameter bit ZERO_REG    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    alu_writeback_if.slave  wb
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] TRAP = 1'b1;

    logic [0:0] state;
    logic [1:0] count;
    wb_entry_t  head;
    wb_entry_t  din;
    logic       push;
    logic       retire;
    logic       head_traps;
    logic       trap_entry;
    logic       ofl_sticky_q;
    logic       err_sticky_q;

    assign din = '{c: wb.in_c, ofl: wb.in_ofl, err: wb.in_err, dst: wb.in_dst};

    // in_ready depends only on registered state so upstream sees no rf_stall path.
    assign wb.in_ready = (count < 2'd2) && (state == RUN);
    assign push        = wb.in_valid && wb.in_ready;
    assign retire      = (state == RUN) && (count != 2'd0) && !wb.rf_stall;
    assign head_traps  = head.err || (TRAP_ON_OFL && head.ofl);
    assign trap_entry  = retire && head_traps;

    assign wb.rf_we      = retire && !head_traps && !(ZERO_REG && (head.dst == '0));
    assign wb.rf_addr    = head.dst;
    assign wb.rf_wdata   = head.c;
    assign wb.trap       = trap_entry;
    assign wb.halted     = (state == TRAP);
    assign wb.ofl_sticky = ofl_sticky_q;
    assign wb.err_sticky = err_sticky_q;

    wb_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (retire),
        .flush (trap_entry),
        .din   (din),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else if (state == RUN) begin
            if (trap_entry) state <= TRAP;
        end else if (wb.trap_ack) begin
            state <= RUN;
        end
    end

    // A retiring flagged entry wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofl_sticky_q <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            if (retire && head.ofl)  ofl_sticky_q <= 1'b1;
            else if (wb.status_clr)  ofl_sticky_q <= 1'b0;
            if (retire && head.err)  err_sticky_q <= 1'b1;
            else if (wb.status_clr)  err_sticky_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, a stall/backpressure
// sequence, and randomized traffic checked against a queue-based reference model.
module tb_alu_writeback;
    import flow_pkg::*;

    localparam bit TOF = 1'b0;
    localparam bit ZR  = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_writeback_if bus ();

    alu_writeback #(.TRAP_ON_OFL(TOF), .ZERO_REG(ZR)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    typedef struct {
        logic        rst, vld;
        logic [15:0] c;
        logic        ofl, err;
        logic [3:0]  dst;
        logic        stall, clr, ack;
        logic        e_rdy, e_we;
        logic [3:0]  e_addr;
        logic [15:0] e_data;
        logic        e_trap, e_halt, e_ofls, e_errs;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;

    task automatic row(input logic r, v, input logic [15:0] c, input logic o, e,
                       input logic [3:0] d, input logic s, cl, a,
                       input logic rdy, we, input logic [3:0] ad, input logic [15:0] dat,
                       input logic trp, h, os, es);
        vec_t x;
        x = '{r, v, c, o, e, d, s, cl, a, rdy, we, ad, dat, trp, h, os, es};
        vt.push_back(x);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, v, input logic [15:0] c, input logic o, e,
                         input logic [3:0] d, input logic s, cl, a);
        rst = r; bus.in_valid = v; bus.in_c = c; bus.in_ofl = o; bus.in_err = e;
        bus.in_dst = d; bus.rf_stall = s; bus.status_clr = cl; bus.trap_ack = a;
    endtask

    task automatic cmp_all(input string tag, input logic rdy, we, input logic [3:0] ad,
                           input logic [15:0] dat, input logic trp, h, os, es);
        chk({tag, ".in_ready"}, 16'(bus.in_ready), 16'(rdy));
        chk({tag, ".rf_we"}, 16'(bus.rf_we), 16'(we));
        if (we) begin
            chk({tag, ".rf_addr"}, 16'(bus.rf_addr), 16'(ad));
            chk({tag, ".rf_wdata"}, bus.rf_wdata, dat);
        end
        chk({tag, ".trap"}, 16'(bus.trap), 16'(trp));
        chk({tag, ".halted"}, 16'(bus.halted), 16'(h));
        chk({tag, ".ofl_sticky"}, 16'(bus.ofl_sticky), 16'(os));
        chk({tag, ".err_sticky"}, 16'(bus.err_sticky), 16'(es));
    endtask

    // Reference model state
    wb_entry_t q[$];
    bit m_halt, m_ofls, m_errs;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        //   rst vld c        o e d  s cl a | rdy we addr data    trp h os es
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'h1234, 0, 0, 3, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 1, 3, 16'h1234, 0, 0, 0, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'h00AA, 1, 0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'h0055, 1, 0, 7, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0,  1, 1, 7, 16'h0055, 0, 0, 1, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 1, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0,  1, 0, 0, 16'h0000, 0, 0, 1, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'hDEAD, 0, 1, 2, 1, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'h5555, 0, 0, 5, 1, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 1, 0, 0, 0);
        row(0, 1, 16'h1111, 0, 0, 6, 0, 0, 0,  0, 0, 0, 16'h0000, 0, 1, 0, 1);
        row(0, 1, 16'h1111, 0, 0, 6, 0, 0, 1,  0, 0, 0, 16'h0000, 0, 1, 0, 1);
        row(0, 1, 16'h1111, 0, 0, 6, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 1);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 1, 6, 16'h1111, 0, 0, 0, 1);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 1, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 1);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 1,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'h0001, 0, 1, 1, 1, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'h0002, 0, 0, 2, 1, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'h0003, 0, 0, 3, 1, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(1, 1, 16'h0003, 0, 0, 3, 1, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 1, 16'h0BAD, 0, 1, 4, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, 1, 0, 0, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 0, 1, 0, 1);
        row(1, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 0, 1, 0, 1);
        row(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);

        foreach (vt[i]) begin
            #1;
            drive(vt[i].rst, vt[i].vld, vt[i].c, vt[i].ofl, vt[i].err, vt[i].dst,
                  vt[i].stall, vt[i].clr, vt[i].ack);
            #2;
            cmp_all($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_we, vt[i].e_addr,
                    vt[i].e_data, vt[i].e_trap, vt[i].e_halt, vt[i].e_ofls, vt[i].e_errs);
            @(posedge clk);
        end

        // Backpressure: three back-to-back results against four stalled cycles.
        #1; drive(0, 1, 16'hA000, 0, 0, 8, 1, 0, 0); #2; cmp_all("bp0", 1, 0, 0, 0, 0, 0, 0, 0); @(posedge clk);
        #1; drive(0, 1, 16'hA001, 0, 0, 9, 1, 0, 0); #2; cmp_all("bp1", 1, 0, 0, 0, 0, 0, 0, 0); @(posedge clk);
        #1; drive(0, 1, 16'hA002, 0, 0, 10, 1, 0, 0); #2; cmp_all("bp2", 0, 0, 0, 0, 0, 0, 0, 0); @(posedge clk);
        #1; drive(0, 1, 16'hA002, 0, 0, 10, 1, 0, 0); #2; cmp_all("bp3", 0, 0, 0, 0, 0, 0, 0, 0); @(posedge clk);
        #1; drive(0, 1, 16'hA002, 0, 0, 10, 0, 0, 0); #2; cmp_all("bp4", 0, 1, 8, 16'hA000, 0, 0, 0, 0); @(posedge clk);
        #1; drive(0, 1, 16'hA002, 0, 0, 10, 0, 0, 0); #2; cmp_all("bp5", 1, 1, 9, 16'hA001, 0, 0, 0, 0); @(posedge clk);
        #1; drive(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0); #2; cmp_all("bp6", 1, 1, 10, 16'hA002, 0, 0, 0, 0); @(posedge clk);
        #1; drive(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0); #2; cmp_all("bp7", 1, 0, 0, 0, 0, 0, 0, 0); @(posedge clk);

        // Randomized traffic against the queue model.
        #1; drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        q.delete(); m_halt = 0; m_ofls = 0; m_errs = 0;
        begin
            bit pend = 0;
            wb_entry_t cur;
            for (int unsigned n = 0; n < 3000; n++) begin
                bit r, v, s, cl, a, rdy, ret, we, trp, hold;
                wb_entry_t h;
                #1;
                if (!pend) begin
                    cur.c   = 16'($urandom);
                    cur.ofl = ($urandom_range(0, 4) == 0);
                    cur.err = ($urandom_range(0, 19) == 0);
                    cur.dst = 4'($urandom);
                end
                v  = pend || ($urandom_range(0, 9) < 6);
                s  = ($urandom_range(0, 9) < 3);
                cl = ($urandom_range(0, 9) == 0);
                a  = ($urandom_range(0, 9) < 3);
                r  = ($urandom_range(0, 199) == 0);
                drive(r, v, cur.c, cur.ofl, cur.err, cur.dst, s, cl, a);
                #2;
                rdy = !m_halt && (q.size() < 2);
                ret = !m_halt && (q.size() > 0) && !s;
                h   = (q.size() > 0) ? q[0] : '0;
                trp = ret && (h.err || (TOF && h.ofl));
                we  = ret && !trp && !(ZR && h.dst == 0);
                cmp_all($sformatf("rnd%0d", n), rdy, we, h.dst, h.c, trp, m_halt, m_ofls, m_errs);
                hold = v && !rdy;
                if (r) begin
                    q.delete(); m_halt = 0; m_ofls = 0; m_errs = 0;
                end else begin
                    if (ret) void'(q.pop_front());
                    if (ret && h.ofl) m_ofls = 1; else if (cl) m_ofls = 0;
                    if (ret && h.err) m_errs = 1; else if (cl) m_errs = 0;
                    if (m_halt) begin
                        if (a) m_halt = 0;
                    end else if (trp) begin
                        m_halt = 1;
                        q.delete();
                    end else if (v && rdy) begin
                        q.push_back(cur);
                    end
                end
                pend = hold && !r;
                @(posedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
